// File: rtl/entrada_condicionador.sv
// -----------------------------------------------------------------------------
// entrada_condicionador
//
// Input conditioning for the Nios system. The raw board inputs (active-low
// start pushbutton and the slide switches) are synchronized to clk_clk and
// debounced. Clean levels go to the start and chave PIOs, and single-cycle
// event pulses are made for local hardware.
//
// Ports:
//   clk_clk          in   system clock (50 MHz), rising edge
//   reset_reset      in   asynchronous reset, active-high
//   key_start_n      in   raw start pushbutton, active-low, bouncy
//   sw_chave         in   raw slide switches [CHAVE_W-1:0], bouncy
//   start_o          out  debounced start level, 1 = pressed
//   start_pulse_o    out  one-cycle pulse on an accepted press
//   chave_o          out  debounced switch vector [CHAVE_W-1:0]
//   chave_changed_o  out  one-cycle pulse when chave_o takes a new value
//
// Handshake: there is none. Every output is a free-running registered level
// or a one-cycle pulse. A consumer samples on any rising edge of clk_clk. No
// back-pressure exists and no pulse is ever held waiting for acceptance.
//
// Debug: the start FSM state is the internal signal `state` (start_state_t).
// Checkers can bind to it directly.
// -----------------------------------------------------------------------------
module entrada_condicionador #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CHAVE_W         = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               key_start_n,
    input  logic [CHAVE_W-1:0] sw_chave,
    output logic               start_o,
    output logic               start_pulse_o,
    output logic [CHAVE_W-1:0] chave_o,
    output logic               chave_changed_o
);

    // 24 bits covers the full legal DEBOUNCE_CYCLES range (2 .. 2^24-1).
    localparam int             CNT_W    = 24;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_SOLTO   = 2'd0,
        CONF_APERTO  = 2'd1,
        APERTADO     = 2'd2,
        CONF_SOLTURA = 2'd3
    } start_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. The start synchronizer resets to 1, which is
    // the released level of the active-low pushbutton.
    // ------------------------------------------------------------------
    logic               key_meta;
    logic               key_sync;
    logic [CHAVE_W-1:0] sw_meta;
    logic [CHAVE_W-1:0] sw_sync;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= key_start_n;
            key_sync <= key_meta;
            sw_meta  <= sw_chave;
            sw_sync  <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Start channel FSM
    // ------------------------------------------------------------------
    start_state_t     state;
    start_state_t     state_next;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_s_next;
    logic             pressed;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE_SOLTO;
            cnt_s <= '0;
        end else begin
            state <= state_next;
            cnt_s <= cnt_s_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_s_next = cnt_s;
        case (state)
            IDLE_SOLTO: begin
                if (!key_sync) begin
                    cnt_s_next = CNT_ONE;
                    state_next = CONF_APERTO;
                end
            end
            CONF_APERTO: begin
                if (key_sync) begin
                    // Bounce: the press did not hold long enough.
                    cnt_s_next = '0;
                    state_next = IDLE_SOLTO;
                end else if (cnt_s == CNT_LAST) begin
                    cnt_s_next = '0;
                    state_next = APERTADO;
                end else begin
                    cnt_s_next = cnt_s + CNT_ONE;
                end
            end
            APERTADO: begin
                if (key_sync) begin
                    cnt_s_next = CNT_ONE;
                    state_next = CONF_SOLTURA;
                end
            end
            CONF_SOLTURA: begin
                if (!key_sync) begin
                    cnt_s_next = '0;
                    state_next = APERTADO;
                end else if (cnt_s == CNT_LAST) begin
                    cnt_s_next = '0;
                    state_next = IDLE_SOLTO;
                end else begin
                    cnt_s_next = cnt_s + CNT_ONE;
                end
            end
            default: begin
                cnt_s_next = '0;
                state_next = IDLE_SOLTO;
            end
        endcase
    end

    // The debounced level is the accepted-press region of the FSM. start_o is
    // registered from the state, so the start channel has the same end-to-end
    // latency as the switch channel: 2 + DEBOUNCE_CYCLES edges after the first
    // sampling edge. Both pulses can therefore line up for simultaneous input.
    assign pressed = (state == APERTADO) || (state == CONF_SOLTURA);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            start_o       <= 1'b0;
            start_pulse_o <= 1'b0;
        end else begin
            start_o       <= pressed;
            start_pulse_o <= pressed & ~start_o;
        end
    end

    // ------------------------------------------------------------------
    // Switch channel. One stability window is shared by the whole vector, so
    // a burst of changes on any bits yields one update to the final value.
    // ------------------------------------------------------------------
    logic [CHAVE_W-1:0] prev;
    logic [CNT_W-1:0]   cnt_c;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            prev            <= '0;
            cnt_c           <= '0;
            chave_o         <= '0;
            chave_changed_o <= 1'b0;
        end else begin
            chave_changed_o <= 1'b0;
            prev            <= sw_sync;
            if (sw_sync != prev) begin
                cnt_c <= '0;
            end else if (cnt_c < CNT_LAST) begin
                cnt_c <= cnt_c + CNT_ONE;
            end else if (sw_sync != chave_o) begin
                chave_o         <= sw_sync;
                chave_changed_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_entrada_condicionador.sv
module tb_entrada_condicionador;

  localparam int D = 8;
  localparam int W = 4;
  // An output changes on the (2+D)th edge after the edge that first samples a
  // new input. Counting that sampling edge as tick 1 gives tick 1+2+D.
  localparam int LAT = 1 + 2 + D;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_n;
  logic [W-1:0] sw;
  logic         start_o;
  logic         start_pulse_o;
  logic [W-1:0] chave_o;
  logic         chave_changed_o;

  int n_checks = 0;
  int n_fail   = 0;

  entrada_condicionador #(
    .DEBOUNCE_CYCLES(D),
    .CHAVE_W(W)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .key_start_n(key_n),
    .sw_chave(sw),
    .start_o(start_o),
    .start_pulse_o(start_pulse_o),
    .chave_o(chave_o),
    .chave_changed_o(chave_changed_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Raw inputs are delayed two edges (synchronizer), and then judged on their
  // recent history. The button level flips once the last D synchronized
  // samples all oppose it. The published start_o trails that decision by one
  // edge. The switch vector is accepted once D+1 consecutive synchronized
  // samples agree. The reset state counts as one agreeing sample of 0.
  bit           key_q[$];
  logic [W-1:0] sw_q[$];
  bit           ks_hist[$];
  logic [W-1:0] ss_hist[$];
  bit           m_level;
  logic         m_start;
  logic         m_pulse;
  logic [W-1:0] m_chave;
  logic         m_changed;

  task automatic model_reset();
    key_q.delete();   key_q.push_back(1'b1); key_q.push_back(1'b1);
    sw_q.delete();    sw_q.push_back('0);    sw_q.push_back('0);
    ks_hist.delete();
    ss_hist.delete(); ss_hist.push_back('0);
    m_level = 1'b0; m_start = 1'b0; m_pulse = 1'b0;
    m_chave = '0;   m_changed = 1'b0;
  endtask

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    bit           ks;
    logic [W-1:0] ss;
    bit           agree;
    @(posedge clk);
    #1;
    key_q.push_back(key_n);
    ks = key_q.pop_front();
    sw_q.push_back(sw);
    ss = sw_q.pop_front();

    m_pulse = m_level & ~m_start;
    m_start = m_level;
    ks_hist.push_back(ks);
    if (ks_hist.size() > D) void'(ks_hist.pop_front());
    if (ks_hist.size() == D) begin
      agree = 1'b1;
      foreach (ks_hist[i]) if (ks_hist[i] != m_level) agree = 1'b0;
      if (agree) m_level = ~m_level;
    end

    m_changed = 1'b0;
    ss_hist.push_back(ss);
    if (ss_hist.size() > D + 1) void'(ss_hist.pop_front());
    if (ss_hist.size() == D + 1) begin
      agree = 1'b1;
      foreach (ss_hist[i]) if (ss_hist[i] != ss) agree = 1'b0;
      if (agree && ss != m_chave) begin
        m_chave   = ss;
        m_changed = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    key_n = 1'b0; sw = 4'hA;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL reset_pre start_o got %b exp %b", start_o, m_start); end
      n_checks++; if (chave_o !== m_chave) begin n_fail++; $display("FAIL reset_pre chave_o got %h exp %h", chave_o, m_chave); end
    end
    n_checks++; if (start_o !== 1'b1) begin n_fail++; $display("FAIL reset_setup start_o got %b exp 1", start_o); end
    n_checks++; if (chave_o !== 4'hA) begin n_fail++; $display("FAIL reset_setup chave_o got %h exp a", chave_o); end
    rst = 1'b1;
    #1;
    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_async start_o got %b exp 0", start_o); end
    n_checks++; if (start_pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_async start_pulse_o got %b exp 0", start_pulse_o); end
    n_checks++; if (chave_o !== 4'h0) begin n_fail++; $display("FAIL reset_async chave_o got %h exp 0", chave_o); end
    n_checks++; if (chave_changed_o !== 1'b0) begin n_fail++; $display("FAIL reset_async chave_changed_o got %b exp 0", chave_changed_o); end
    key_n = 1'b1; sw = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle start_o cyc %0d got %b exp 0", i, start_o); end
      n_checks++; if (start_pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle start_pulse_o cyc %0d got %b exp 0", i, start_pulse_o); end
      n_checks++; if (chave_o !== 4'h0) begin n_fail++; $display("FAIL reset_idle chave_o cyc %0d got %h exp 0", i, chave_o); end
      n_checks++; if (chave_changed_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle chave_changed_o cyc %0d got %b exp 0", i, chave_changed_o); end
    end
  endtask

  task automatic test_clean_press();
    int edge_at;
    int pulses;
    edge_at = 0; pulses = 0;
    key_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL press start_o cyc %0d got %b exp %b", i, start_o, m_start); end
      n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL press start_pulse_o cyc %0d got %b exp %b", i, start_pulse_o, m_pulse); end
      if (start_o === 1'b1 && edge_at == 0) edge_at = i;
      if (start_pulse_o === 1'b1) pulses++;
    end
    n_checks++; if (edge_at != LAT) begin n_fail++; $display("FAIL press_latency got %0d exp %0d", edge_at, LAT); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL press_pulse_count got %0d exp 1", pulses); end
    edge_at = 0; pulses = 0;
    key_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL release start_o cyc %0d got %b exp %b", i, start_o, m_start); end
      n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL release start_pulse_o cyc %0d got %b exp %b", i, start_pulse_o, m_pulse); end
      if (start_o === 1'b0 && edge_at == 0) edge_at = i;
      if (start_pulse_o === 1'b1) pulses++;
    end
    n_checks++; if (edge_at != LAT) begin n_fail++; $display("FAIL release_latency got %0d exp %0d", edge_at, LAT); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL release_pulse_count got %0d exp 0", pulses); end
  endtask

  task automatic test_bounce();
    bit lvl[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int len[6]   = '{5, 3, 6, 100, 40, 20};
    int pulses_a;
    int pulses_b;
    int highs_a;
    pulses_a = 0; pulses_b = 0; highs_a = 0;
    for (int s = 0; s < 6; s++) begin
      key_n = lvl[s];
      for (int i = 0; i < len[s]; i++) begin
        tick();
        n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL bounce start_o seg %0d cyc %0d got %b exp %b", s, i, start_o, m_start); end
        n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL bounce start_pulse_o seg %0d cyc %0d got %b exp %b", s, i, start_pulse_o, m_pulse); end
        if (s < 4) begin
          if (start_pulse_o === 1'b1) pulses_a++;
          if (start_o === 1'b1) highs_a++;
        end else if (start_pulse_o === 1'b1) begin
          pulses_b++;
        end
      end
    end
    n_checks++; if (pulses_a != 0) begin n_fail++; $display("FAIL bounce_pulses got %0d exp 0", pulses_a); end
    n_checks++; if (highs_a != 0) begin n_fail++; $display("FAIL bounce_level_high_cycles got %0d exp 0", highs_a); end
    n_checks++; if (pulses_b != 1) begin n_fail++; $display("FAIL bounce_hold_pulses got %0d exp 1", pulses_b); end
  endtask

  task automatic test_switch();
    int edge_at;
    int changes;
    int bad_values;
    edge_at = 0; changes = 0; bad_values = 0;
    sw = 4'b0101;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++; if (chave_o !== m_chave) begin n_fail++; $display("FAIL switch chave_o cyc %0d got %h exp %h", i, chave_o, m_chave); end
      n_checks++; if (chave_changed_o !== m_changed) begin n_fail++; $display("FAIL switch chave_changed_o cyc %0d got %b exp %b", i, chave_changed_o, m_changed); end
      if (chave_changed_o === 1'b1) begin changes++; if (edge_at == 0) edge_at = i; end
    end
    n_checks++; if (edge_at != LAT) begin n_fail++; $display("FAIL switch_latency got %0d exp %0d", edge_at, LAT); end
    n_checks++; if (changes != 1) begin n_fail++; $display("FAIL switch_change_count got %0d exp 1", changes); end
    n_checks++; if (chave_o !== 4'h5) begin n_fail++; $display("FAIL switch_value got %h exp 5", chave_o); end
    changes = 0;
    for (int i = 0; i < 45; i++) begin
      if (i < 20 && (i % 4) == 0) sw = sw ^ 4'b1000;
      tick();
      n_checks++; if (chave_o !== m_chave) begin n_fail++; $display("FAIL switch_burst chave_o cyc %0d got %h exp %h", i, chave_o, m_chave); end
      n_checks++; if (chave_changed_o !== m_changed) begin n_fail++; $display("FAIL switch_burst chave_changed_o cyc %0d got %b exp %b", i, chave_changed_o, m_changed); end
      if (chave_changed_o === 1'b1) changes++;
      if (chave_o !== 4'h5 && chave_o !== 4'hD) bad_values++;
    end
    n_checks++; if (changes != 1) begin n_fail++; $display("FAIL switch_burst_changes got %0d exp 1", changes); end
    n_checks++; if (bad_values != 0) begin n_fail++; $display("FAIL switch_burst_intermediate got %0d exp 0", bad_values); end
    n_checks++; if (chave_o !== 4'hD) begin n_fail++; $display("FAIL switch_burst_final got %h exp d", chave_o); end
  endtask

  task automatic test_simultaneous();
    int sp_at;
    int cc_at;
    bit both_ok;
    sp_at = 0; cc_at = 0; both_ok = 1'b0;
    key_n = 1'b1; sw = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (chave_o !== m_chave) begin n_fail++; $display("FAIL simul_prep chave_o cyc %0d got %h exp %h", i, chave_o, m_chave); end
    end
    key_n = 1'b0; sw = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL simul start_pulse_o cyc %0d got %b exp %b", i, start_pulse_o, m_pulse); end
      n_checks++; if (chave_changed_o !== m_changed) begin n_fail++; $display("FAIL simul chave_changed_o cyc %0d got %b exp %b", i, chave_changed_o, m_changed); end
      if (start_pulse_o === 1'b1 && sp_at == 0) sp_at = i;
      if (chave_changed_o === 1'b1 && cc_at == 0) cc_at = i;
      if (start_pulse_o === 1'b1 && chave_changed_o === 1'b1 && start_o === 1'b1 && chave_o === 4'hF) both_ok = 1'b1;
    end
    n_checks++; if (sp_at != LAT || cc_at != LAT) begin n_fail++; $display("FAIL simul_alignment start_pulse at %0d chave_changed at %0d exp both %0d", sp_at, cc_at, LAT); end
    n_checks++; if (!both_ok) begin n_fail++; $display("FAIL simul_levels got start_o=%b chave_o=%h exp 1 and f in the pulse cycle", start_o, chave_o); end
    key_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL simul_release start_o cyc %0d got %b exp %b", i, start_o, m_start); end
    end
  endtask

  task automatic test_reset_mid();
    int edge_at;
    edge_at = 0;
    key_n = 1'b0;
    // Eight edges put the confirmation count at 6.
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL rmid_pre start_o cyc %0d got %b exp %b", i, start_o, m_start); end
    end
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset start_o cyc %0d got %b exp 0", i, start_o); end
      n_checks++; if (start_pulse_o !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset start_pulse_o cyc %0d got %b exp 0", i, start_pulse_o); end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL rmid_post start_o cyc %0d got %b exp %b", i, start_o, m_start); end
      n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL rmid_post start_pulse_o cyc %0d got %b exp %b", i, start_pulse_o, m_pulse); end
      if (start_o === 1'b1 && edge_at == 0) edge_at = i;
    end
    n_checks++; if (edge_at != LAT) begin n_fail++; $display("FAIL rmid_latency got %0d exp %0d", edge_at, LAT); end
    key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_random();
    int hold;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 1) == 1) key_n = ~key_n;
      if ($urandom_range(0, 2) != 0) sw = W'($urandom_range(0, 15));
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++) begin
        tick();
        n_checks++; if (start_o !== m_start) begin n_fail++; $display("FAIL random start_o seg %0d got %b exp %b", s, start_o, m_start); end
        n_checks++; if (start_pulse_o !== m_pulse) begin n_fail++; $display("FAIL random start_pulse_o seg %0d got %b exp %b", s, start_pulse_o, m_pulse); end
        n_checks++; if (chave_o !== m_chave) begin n_fail++; $display("FAIL random chave_o seg %0d got %h exp %h", s, chave_o, m_chave); end
        n_checks++; if (chave_changed_o !== m_changed) begin n_fail++; $display("FAIL random chave_changed_o seg %0d got %b exp %b", s, chave_changed_o, m_changed); end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500us;
    $display("FAIL watchdog time limit reached, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; key_n = 1'b1; sw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL por start_o got %b exp 0", start_o); end
    n_checks++; if (start_pulse_o !== 1'b0) begin n_fail++; $display("FAIL por start_pulse_o got %b exp 0", start_pulse_o); end
    n_checks++; if (chave_o !== 4'h0) begin n_fail++; $display("FAIL por chave_o got %h exp 0", chave_o); end
    n_checks++; if (chave_changed_o !== 1'b0) begin n_fail++; $display("FAIL por chave_changed_o got %b exp 0", chave_changed_o); end
    rst = 1'b0;
    model_reset();

    test_reset();
    test_clean_press();
    test_bounce();
    test_switch();
    test_simultaneous();
    test_reset_mid();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entrada_condicionador.md
Name: entrada_condicionador

Overview:
- Input conditioning stage directly upstream of the Nios system.
- Takes the raw, asynchronous board inputs: the active-low start pushbutton and the 4 selector switches.
- Synchronizes and debounces them, then drives the system's start PIO and 4-bit switch PIO with clean levels.
- Also emits single-cycle event pulses for local hardware use.

Parameters:
- DEBOUNCE_CYCLES, 500000, clocks an input must stay stable before it is accepted (10 ms at 50 MHz); legal range 2..2^24-1.
- CHAVE_W, 4, width of the switch vector.

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset  input  1  asynchronous reset, active-high.
- key_start_n  input  1  raw pushbutton, active-low, asynchronous, bouncy.
- sw_chave  input  CHAVE_W  raw slide switches, asynchronous, bouncy.
- start_o  output  1  debounced start level, 1 = pressed; feeds the start PIO.
- start_pulse_o  output  1  one-cycle pulse on accepted press (0->1 of start_o).
- chave_o  output  CHAVE_W  debounced switch vector; feeds the chave PIO.
- chave_changed_o  output  1  one-cycle pulse when chave_o takes a new value.

Behaviour:
- Reset is asynchronous and active-high; clocking is single-clock, rising edge.
- While reset_reset=1:
  - start_o=0, start_pulse_o=0, chave_o=0, chave_changed_o=0.
  - Start synchronizer flops = 1 (released).
  - Switch synchronizer flops = 0.
  - All counters = 0; start FSM in IDLE_SOLTO.
- Reset may assert at any time. The block returns to the reset state immediately, with no partial update, and the pulses drop immediately.
- Synchronization: each raw bit passes through a 2-flop synchronizer. Only the second-stage value (sync) is used downstream.
- Start channel FSM (states IDLE_SOLTO, CONF_APERTO, APERTADO, CONF_SOLTURA; counter cnt_s):
  - IDLE_SOLTO: start_o=0. If sync=0 (pressed): cnt_s<=1, go CONF_APERTO.
  - CONF_APERTO: if sync=1, go IDLE_SOLTO and clear cnt_s (bounce rejected). Else if cnt_s=DEBOUNCE_CYCLES-1, go APERTADO, set start_o=1 and assert start_pulse_o for exactly that one cycle. Else cnt_s++.
  - APERTADO: start_o=1. If sync=1: cnt_s<=1, go CONF_SOLTURA.
  - CONF_SOLTURA: if sync=0, go APERTADO and clear cnt_s. Else if cnt_s=DEBOUNCE_CYCLES-1, go IDLE_SOLTO and set start_o=0 (no pulse). Else cnt_s++.
- Start latency: with a clean press, start_o rises exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples key_start_n=0. Release is symmetric.
- Switch channel (shared counter cnt_c, registered last-sample vector prev):
  - Each cycle prev<=sync.
  - If sync!=prev, cnt_c<=0 (any bit change restarts the window for the whole vector).
  - Else, if cnt_c<DEBOUNCE_CYCLES-1, cnt_c++.
  - Else (saturated, stable): if sync!=chave_o, then chave_o<=sync and chave_changed_o=1 for one cycle.
  - cnt_c saturates and never wraps.
- Multiple switch bits changing in one cycle or in quick succession produce one single update to the final stable vector; no intermediate value is ever shown.
- Simultaneous button and switch activity is handled independently; both pulses may assert in the same cycle.
- A held button produces exactly one start_pulse_o, regardless of hold duration.
- Pulses shorter than DEBOUNCE_CYCLES never reach any output.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=8 and a 10 ns clock.)
- Reset values: assert reset_reset mid-run with start_o=1 and chave_o=4'hA -> all outputs 0 asynchronously. After release with inputs idle (key_start_n=1, sw_chave=0), outputs stay 0 for 50 cycles.
- Clean press: drive key_start_n 1->0 and hold 30 cycles -> start_o rises on cycle 10 after the first sampled 0. start_pulse_o is high for exactly that cycle. Release -> start_o falls 10 cycles after, with no pulse.
- Bounce rejection: toggle key_start_n low for 5 cycles, high 3, low 6, high 100 -> start_o and start_pulse_o stay 0 throughout. Then hold low for 40 cycles -> exactly one start_pulse_o.
- Switch update: sw_chave 0->4'b0101, held -> chave_o=5 exactly 2+8 cycles later, with chave_changed_o pulsed once. Then change bit 3 each 4 cycles for 20 cycles and settle at 4'b1101 -> a single update to 4'hD, with no intermediate values.
- Simultaneous events: press the button and set sw_chave=4'hF in the same cycle -> start_pulse_o and chave_changed_o assert in the same cycle, with start_o=1 and chave_o=4'hF.
- Reset mid-confirmation: press the button and assert reset at count 6 -> start_o stays 0. After release with the button still held, a full 2+8 cycles pass before start_o=1.
